// File: rtl/sonar_wb_pkg.sv
// Shared register map, bit positions and reset values for the sonar Wishbone register block.
// Optional interrupt support is enabled by defining SONAR_WB_IRQ_EN.
package sonar_wb_pkg;

  typedef enum logic [2:0] {
    OFF_CTRL      = 3'd0,
    OFF_STATUS    = 3'd1,
    OFF_GPIO_OUT  = 3'd2,
    OFF_GPIO_OEB  = 3'd3,
    OFF_FIFO_DATA = 3'd4,
    OFF_SCRATCH   = 3'd5,
    OFF_RSVD6     = 3'd6,
    OFF_RSVD7     = 3'd7
  } reg_off_e;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_START_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

  localparam int unsigned STATUS_COUNT_MSB = 6;
  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_OVF_BIT   = 10;

  localparam logic [15:0] IO_OUT_RST = 16'h0000;
  localparam logic [15:0] IO_OEB_RST = 16'hFFFF;

  function automatic logic [31:0] merge_sel(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sonar_sample_fifo.sv
// Sample FIFO with power-of-two depth; pops on empty and pushes on full (without a pop) are ignored.
module sonar_sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_sonar_regs.sv
// Wishbone register window for the sonar block: control, status, GPIO, sample FIFO and scratch.
// Define SONAR_WB_IRQ_EN to enable the CTRL.irq_en bit and the irq_o output.
module wb_sonar_regs
  import sonar_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        samp_valid_i,
  input  logic [15:0] samp_data_i,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        start_o,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic           hit;
  logic           new_req;
  logic           wr_en;
  reg_off_e       off;
  logic           enable_q;
  logic           irq_en_q;
  logic           overflow_q;
  logic           pop_arm_q;
  logic [31:0]    scratch_q;
  logic [31:0]    rd_data;
  logic [31:0]    scratch_m;
  logic [31:0]    gpio_out_m;
  logic [31:0]    gpio_oeb_m;
  logic           fifo_push;
  logic           fifo_pop;
  logic [15:0]    fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           ovf_set;
  logic           ovf_clr;
  logic           unused_bits;

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign new_req = hit & ~wbs_ack_o;
  assign wr_en   = wbs_ack_o & hit & wbs_we_i;
  assign off     = reg_off_e'(wbs_adr_i[4:2]);

  assign scratch_m  = merge_sel(scratch_q, wbs_dat_i, wbs_sel_i);
  assign gpio_out_m = merge_sel({16'h0000, io_out}, wbs_dat_i, wbs_sel_i);
  assign gpio_oeb_m = merge_sel({16'h0000, io_oeb}, wbs_dat_i, wbs_sel_i);

  assign fifo_push = samp_valid_i & enable_q;
  // The pop decision is latched when the read data is captured, so the entry popped
  // is always the one returned even if a push lands in between.
  assign fifo_pop  = wbs_ack_o & pop_arm_q;
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
  assign ovf_clr   = wr_en & (off == OFF_STATUS) & wbs_sel_i[1] & wbs_dat_i[STATUS_OVF_BIT];

  assign unused_bits = ^wbs_adr_i[1:0];

  sonar_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (samp_data_i),
    .pop       (fifo_pop),
    .data      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL: begin
        rd_data[CTRL_ENABLE_BIT] = enable_q;
        rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      OFF_STATUS: begin
        rd_data[STATUS_COUNT_MSB:0] = 7'(fifo_count);
        rd_data[STATUS_EMPTY_BIT]   = fifo_empty;
        rd_data[STATUS_FULL_BIT]    = fifo_full;
        rd_data[STATUS_OVF_BIT]     = overflow_q;
      end
      OFF_GPIO_OUT:  rd_data = {16'h0000, io_out};
      OFF_GPIO_OEB:  rd_data = {16'h0000, io_oeb};
      OFF_FIFO_DATA: rd_data = fifo_empty ? '0 : {16'h0000, fifo_head};
      OFF_SCRATCH:   rd_data = scratch_q;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      pop_arm_q  <= 1'b0;
      start_o    <= 1'b0;
      enable_q   <= 1'b0;
      scratch_q  <= '0;
      io_out     <= IO_OUT_RST;
      io_oeb     <= IO_OEB_RST;
      overflow_q <= 1'b0;
    end else begin
      wbs_ack_o <= new_req;
      wbs_dat_o <= new_req ? rd_data : '0;
      pop_arm_q <= new_req & ~wbs_we_i & (off == OFF_FIFO_DATA) & ~fifo_empty;
      start_o   <= wr_en & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START_BIT];

      if (wr_en) begin
        case (off)
          OFF_CTRL:     if (wbs_sel_i[0]) enable_q <= wbs_dat_i[CTRL_ENABLE_BIT];
          OFF_GPIO_OUT: io_out    <= gpio_out_m[15:0];
          OFF_GPIO_OEB: io_oeb    <= gpio_oeb_m[15:0];
          OFF_SCRATCH:  scratch_q <= scratch_m;
          default: ;
        endcase
      end

      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

`ifdef SONAR_WB_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_en && off == OFF_CTRL && wbs_sel_i[0]) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN_BIT];
      irq_o <= irq_en_q & (~fifo_empty | overflow_q);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sonar_regs.sv
// Directed + randomized bench for wb_sonar_regs against a queue-based FIFO/register model.
module tb_wb_sonar_regs;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        samp_valid_i;
  logic [15:0] samp_data_i;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        start_o;
  logic        irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  int          model_q[$];
  bit          model_ovf;
  bit          model_en;
  logic [31:0] model_scratch;

  wb_sonar_regs #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .samp_valid_i (samp_valid_i),
    .samp_data_i  (samp_data_i),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .start_o      (start_o),
    .irq_o        (irq_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = model_q.size();
    return 32'(n) + ((n == 0) ? 32'd256 : 32'd0) + ((n == DEPTH) ? 32'd512 : 32'd0)
           + (model_ovf ? 32'd1024 : 32'd0);
  endfunction

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'd0;
    return 32'(model_q.pop_front());
  endfunction

  task automatic model_push(input logic [15:0] d);
    if (model_en) begin
      if (model_q.size() < DEPTH) model_q.push_back(int'(d));
      else model_ovf = 1'b1;
    end
  endtask

  task automatic push_sample(input logic [15:0] d);
    samp_valid_i = 1'b1;
    samp_data_i  = d;
    @(posedge wb_clk_i); #1;
    samp_valid_i = 1'b0;
    model_push(d);
  endtask

  // One Wishbone cycle; optionally a sample strobe is driven during the ack cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic push_at_ack,
                         input logic [15:0] pdata, output logic [31:0] rdat);
    int lat;
    bit got;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    lat = 0; got = 0;
    while (!got && lat < 50) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (wbs_ack_o) got = 1;
    end
    chk("ack_latency", 32'(lat), 32'd1);
    rdat = wbs_dat_o;
    if (push_at_ack) begin
      samp_valid_i = 1'b1;
      samp_data_i  = pdata;
    end
    @(posedge wb_clk_i); #1;
    samp_valid_i = 1'b0;
    chk("ack_single", {31'b0, wbs_ack_o}, 32'd0);
    chk("dat_idle_zero", wbs_dat_o, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, sel, 1'b0, 16'h0, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b0, 16'h0, rdat);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] e;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [15:0] pd;
    bit          seen_ack;

    wb_rst_i = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0; samp_valid_i = 0; samp_data_i = '0;
    model_ovf = 0; model_en = 0; model_scratch = '0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_io_out", {16'h0, io_out}, 32'h0);
    chk("rst_io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    chk("rst_start", {31'b0, start_o}, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    wb_read(BASE + 32'h04, r);
    chk("rst_status", r, exp_status());

    wb_write(BASE + 32'h08, 32'h0000AB60, 4'hF);
    chk("gpio_out_pin", {16'h0, io_out}, 32'h0000AB60);
    wb_read(BASE + 32'h08, r);
    chk("gpio_out_rd", r, 32'h0000AB60);
    wd = $urandom;
    wb_write(BASE + 32'h0C, wd, 4'hF);
    chk("gpio_oeb_pin", {16'h0, io_oeb}, {16'h0, wd[15:0]});
    wb_read(BASE + 32'h0C, r);
    chk("gpio_oeb_rd", r, {16'h0, wd[15:0]});

    wb_write(BASE + 32'h14, 32'h11223344, 4'hF);
    wb_write(BASE + 32'h14, 32'h0000CD00, 4'b0010);
    wb_read(BASE + 32'h14, r);
    chk("scratch_byte", r, 32'h1122CD44);
    model_scratch = 32'h1122CD44;
    for (int i = 0; i < 6; i++) begin
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      wb_write(BASE + 32'h14, wd, ws);
      e = 32'h0;
      for (int b = 0; b < 4; b++)
        e = e | ((ws[b] ? wd : model_scratch) & (32'hFF << (8 * b)));
      model_scratch = e;
      wb_read(BASE + 32'h14, r);
      chk("scratch_rand", r, model_scratch);
    end

    wb_write(BASE + 32'h18, 32'hFFFFFFFF, 4'hF);
    wb_read(BASE + 32'h18, r);
    chk("rsvd18", r, 32'h0);
    wb_read(BASE + 32'h1C, r);
    chk("rsvd1c", r, 32'h0);
    wb_write(BASE + 32'h10, 32'h0000BEEF, 4'hF);
    wb_read(BASE + 32'h04, r);
    chk("fifo_wr_ignored", r, exp_status());

    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0040; wbs_sel_i = 4'hF;
    seen_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen_ack = 1;
    end
    chk("miss_no_ack", {31'b0, seen_ack}, 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_adr_i = '0;

    wb_write(BASE + 32'h00, 32'h2, 4'hF);
    chk("start_high", {31'b0, start_o}, 32'd1);
    @(posedge wb_clk_i); #1;
    chk("start_low", {31'b0, start_o}, 32'd0);
    wb_read(BASE + 32'h00, r);
    chk("ctrl_start_rd0", r, 32'h0);
    push_sample(16'h5555);
    wb_read(BASE + 32'h04, r);
    chk("disabled_no_push", r, exp_status());

    wb_write(BASE + 32'h00, 32'h1, 4'hF);
    model_en = 1;
    for (int i = 1; i <= 9; i++) push_sample(16'(i));
    wb_read(BASE + 32'h04, r);
    chk("status_full_ovf", r, 32'h00000608);
    chk("status_full_model", r, exp_status());
    for (int i = 1; i <= 8; i++) begin
      wb_read(BASE + 32'h10, r);
      chk("fifo_seq", r, 32'(i));
      e = model_pop();
    end
    wb_read(BASE + 32'h10, r);
    chk("fifo_empty_rd", r, 32'h0);
    wb_read(BASE + 32'h04, r);
    chk("status_empty", r, exp_status());

    for (int i = 0; i < DEPTH; i++) push_sample(16'($urandom));
    wb_read(BASE + 32'h04, r);
    chk("refill_status", r, exp_status());
    pd = 16'($urandom);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, pd, r);
    e = model_pop();
    model_push(pd);
    chk("pushpop_data", r, e);
    wb_read(BASE + 32'h04, r);
    chk("pushpop_status", r, exp_status());
    wb_write(BASE + 32'h04, 32'h00000400, 4'hF);
    model_ovf = 0;
    wb_read(BASE + 32'h04, r);
    chk("w1c_status", r, exp_status());
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(BASE + 32'h10, r);
      chk("drain", r, model_pop());
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: push_sample(16'($urandom));
        2: begin
          wb_read(BASE + 32'h10, r);
          chk("rand_fifo", r, model_pop());
        end
        default: begin
          wb_read(BASE + 32'h04, r);
          chk("rand_status", r, exp_status());
        end
      endcase
    end

    while (model_q.size() > 0) begin
      wb_read(BASE + 32'h10, r);
      chk("rand_drain", r, model_pop());
    end
    wb_write(BASE + 32'h04, 32'h00000400, 4'hF);
    model_ovf = 0;
    wb_read(BASE + 32'h04, r);
    chk("pre_irq_status", r, exp_status());
    wb_write(BASE + 32'h00, 32'h5, 4'hF);
`ifdef SONAR_WB_IRQ_EN
    wb_read(BASE + 32'h00, r);
    chk("ctrl_irq_rd", r, 32'h5);
    chk("irq_idle", {31'b0, irq_o}, 32'd0);
    push_sample(16'h00A5);
    @(posedge wb_clk_i); #1;
    chk("irq_raised", {31'b0, irq_o}, 32'd1);
`else
    wb_read(BASE + 32'h00, r);
    chk("ctrl_no_irq_rd", r, 32'h1);
    push_sample(16'h00A5);
    @(posedge wb_clk_i); #1;
    chk("irq_tied", {31'b0, irq_o}, 32'd0);
`endif

    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE + 32'h08;
    wbs_dat_i = 32'h00001234; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    chk("pre_rst_ack", {31'b0, wbs_ack_o}, 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("midrst_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("midrst_io_out", {16'h0, io_out}, 32'h0);
    chk("midrst_io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    chk("midrst_start", {31'b0, start_o}, 32'd0);
    wb_rst_i = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    model_q.delete(); model_ovf = 0; model_en = 0; model_scratch = '0;
    @(posedge wb_clk_i); #1;
    chk("postrst_io_out", {16'h0, io_out}, 32'h0);
    wb_read(BASE + 32'h14, r);
    chk("postrst_scratch", r, model_scratch);
    wb_read(BASE + 32'h00, r);
    chk("postrst_ctrl", r, 32'h0);
    wb_read(BASE + 32'h04, r);
    chk("postrst_status", r, exp_status());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_sonar_regs.md
WB_SONAR_REGS -- requirements
Module: wb_sonar_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: byte base address of the 32-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries; power of two, 2..64.
REQ-003 SHALL have ports: wb_clk_i in 1 (the block's single clock); wb_rst_i in 1 (synchronous, active-high reset).
REQ-004 SHALL have Wishbone slave ports: wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-005 SHALL have sample ports: samp_valid_i in 1 (sample strobe from sonar datapath); samp_data_i in 16 (sample value).
REQ-006 SHALL have outputs: io_out out 16 (GPIO drive); io_oeb out 16 (active-low output enable); start_o out 1 (one-cycle start pulse); irq_o out 1 (interrupt).

Function
REQ-007 SHALL decode a hit when cyc&stb and wbs_adr_i[31:5]==BASE_ADDR[31:5]; offset = wbs_adr_i[4:2].
REQ-008 SHALL assert wbs_ack_o exactly one cycle, in the cycle after a hit, and never in two consecutive cycles (ack only when the hit is seen and ack is currently low).
REQ-009 SHALL not ack a non-hit; the master stalls, and no timeout is built in.
REQ-010 SHALL perform writes on the ack cycle only, per byte lane by wbs_sel_i; wbs_dat_o SHALL be valid on the ack cycle and 0 otherwise.
REQ-011 SHALL implement the map: 0x00 CTRL rw [0]=enable [2]=irq_en; write [1]=1 pulses start_o one cycle, [1] reads 0.
REQ-012 SHALL implement 0x04 STATUS: [6:0]=count, [8]=empty, [9]=full, [10]=overflow (sticky, write-1-clear); other bits read 0.
REQ-013 SHALL implement 0x08 GPIO_OUT rw [15:0]->io_out, and 0x0C GPIO_OEB rw [15:0]->io_oeb.
REQ-014 SHALL implement 0x10 FIFO_DATA: a read returns {16'h0, head} and pops on the ack cycle; an empty read returns 0 with no state change; writes are ignored.
REQ-015 SHALL implement 0x14 SCRATCH rw 32-bit; offsets 0x18 and 0x1C SHALL ack, read 0 and ignore writes.
REQ-016 SHALL push samp_data_i when samp_valid_i and CTRL.enable.
- Push while full and no pop in the same cycle: sample dropped, overflow set.
- Simultaneous push and pop: both occur and count is unchanged, including when full.
- Overflow set and W1C in the same cycle: set wins.
REQ-017 SHALL make the pushed data and the updated count visible to a read ack starting the following cycle.
REQ-018 SHALL keep the FIFO pointers wrap-around modulo FIFO_DEPTH, with count 0..FIFO_DEPTH.

Reset
REQ-019 SHALL, on wb_rst_i high at a clock edge, clear: wbs_ack_o, wbs_dat_o, start_o, irq_o, CTRL, SCRATCH, overflow, pointers, count and io_out to 0, and set io_oeb to 16'hFFFF.
REQ-020 SHALL, if reset arrives mid-transaction, drop the pending write and any pop; ack SHALL be 0 in the cycle after reset.

Configuration
REQ-021 SHALL, with SONAR_WB_IRQ_EN defined, drive irq_o registered = CTRL.irq_en & (!empty | overflow).
REQ-022 SHALL, without SONAR_WB_IRQ_EN, tie irq_o to 0 and make CTRL[2] read 0 and ignore writes.

Structure
REQ-023 SHALL place the register offsets, CTRL/STATUS bit positions and the IO reset value in shared package sonar_wb_pkg.
REQ-024 SHALL implement the FIFO as a sub-module sonar_sample_fifo (push, pop, data, count, full, empty).

Verification
REQ-025 SHALL check: write 0x30000008=32'h0000AB60 with sel=4'hF -> ack exactly 1 cycle later; io_out=16'hAB60; readback 0x0000AB60.
REQ-026 SHALL check: byte write with sel=4'b0010, data 32'h0000CD00 over SCRATCH=32'h11223344 -> reads 32'h1122CD44.
REQ-027 SHALL check: enable=1, push 9 samples 1..9 (depth 8) -> STATUS count=8, full=1, overflow=1; 8 FIFO_DATA reads return 1..8; a 9th read returns 0 with empty=1.
REQ-028 SHALL check: FIFO full, push and pop in the same cycle -> count stays 8, overflow unchanged; W1C of STATUS bit10 clears overflow.
REQ-029 SHALL check: address 0x30000040 with stb&cyc held 20 cycles -> no ack; write CTRL=32'h2 -> start_o high for exactly 1 cycle.
REQ-030 SHALL check: reset asserted in the cycle after a GPIO_OUT write hit -> no ack, io_out=0, io_oeb=16'hFFFF; with SONAR_WB_IRQ_EN and irq_en=1, a single push raises irq_o.
